cpu_clk_ctrl: RTL and testbench

- Run-control stage between the board switches/buttons and the CPU. Issues the CPU clock-enable in one of three modes: free-run at a switch-selected rate, single-step on a debounced button press, or paused.
- Stops issuing enables when the CPU signals halt.
- Provides a retired-enable count for the display path.
- Runs on the board clock; ce_out gates the CPU/RAM registers, so no derived clock is needed.

---
 rtl/cpu_clk_ctrl_pkg.sv | 27 ++
 rtl/cpu_clk_ctrl_if.sv | 25 ++
 rtl/cpu_clk_ctrl_sync_debounce.sv | 65 ++++++
 rtl/cpu_clk_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and defaults for the CPU run-control block: state
// encoding, divider width and default timing parameters.
package cpu_ctrl_pkg;

    // Encoding matches state_out on the board display path.
    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int unsigned DIV_W      = 26;
    localparam int unsigned CE_CNT_W   = 32;

    localparam int unsigned DEBOUNCE_CYC_DEF = 1000000;
    localparam int unsigned DIV0_DEF         = 50000000;
    localparam int unsigned DIV1_DEF         = 5000000;
    localparam int unsigned DIV2_DEF         = 50000;
    localparam int unsigned DIV3_DEF         = 1;

    // Terminal divider value for a ce period of div clk cycles.
    function automatic logic [DIV_W-1:0] div_terminal(input int unsigned div);
        return DIV_W'(div - 1);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Board-side control bundle of the run-control block: switch/button
// inputs, CPU halt, and the clock-enable/status outputs.
interface cpu_clk_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic                sw_run;
    logic                btn_step;
    logic [1:0]          freq_sel;
    logic                cpu_halt;
    logic                ce_out;
    logic [1:0]          state_out;
    logic [CE_CNT_W-1:0] ce_count;

    // Driver side (board / testbench).
    modport master (
        output sw_run, btn_step, freq_sel, cpu_halt,
        input  ce_out, state_out, ce_count
    );

    // Run-control block side.
    modport slave (
        input  sw_run, btn_step, freq_sel, cpu_halt,
        output ce_out, state_out, ce_count
    );
endinterface

// File: rtl/cpu_clk_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter. The accepted
// level only flips after DEBOUNCE_CYC consecutive cycles in which the
// synced input differs from it; rise pulses for one cycle on an
// accepted 0->1 transition.
module sync_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Next-state logic for synchronizer, debounce counter and edge pulse.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned; otherwise synthesis would infer a latch.
        meta_d  = din;
        sync_d  = meta_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                rise_d  = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge value of every other flop.
        if (!rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU run-control: conditions the run switch and step button, then
// issues a registered clock-enable in RUN (divided), STEP (one pulse)
// or none in PAUSE/HALT, and counts issued enables.
module cpu_clk_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned DIV0         = DIV0_DEF,
    parameter int unsigned DIV1         = DIV1_DEF,
    parameter int unsigned DIV2         = DIV2_DEF,
    parameter int unsigned DIV3         = DIV3_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cpu_clk_ctrl_if.slave      bus
);
    localparam int unsigned DIV_MAX = 32'd1 << DIV_W;

    // Divider periods must be non-zero and fit the 26-bit divider.
    if (DIV0 == 0 || DIV0 > DIV_MAX || DIV1 == 0 || DIV1 > DIV_MAX ||
        DIV2 == 0 || DIV2 > DIV_MAX || DIV3 == 0 || DIV3 > DIV_MAX) begin : g_bad_div
        $error("cpu_clk_ctrl: DIVn must be in 1..2^26");
    end
    if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
        $error("cpu_clk_ctrl: DEBOUNCE_CYC must be at least 1");
    end

    localparam logic [DIV_W-1:0] TERM0 = div_terminal(DIV0);
    localparam logic [DIV_W-1:0] TERM1 = div_terminal(DIV1);
    localparam logic [DIV_W-1:0] TERM2 = div_terminal(DIV2);
    localparam logic [DIV_W-1:0] TERM3 = div_terminal(DIV3);

    logic run_db, run_rise;
    logic step_db, step_rise;

    sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sw_run),
        .level (run_db),
        .rise  (run_rise)
    );

    sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.btn_step),
        .level (step_db),
        .rise  (step_rise)
    );

    // Only the run level and the step edge drive the FSM.
    logic unused_ok;
    assign unused_ok = &{1'b1, run_rise, step_db};

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    term;
    logic                ce_q, ce_d;
    logic [CE_CNT_W-1:0] ce_count_q, ce_count_d;

    // Terminal divider value for the currently selected rate.
    always_comb begin
        term = TERM0;
        case (bus.freq_sel)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    // Run-control FSM, divider and enable counter next-state logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        ce_d       = 1'b0;
        ce_count_d = ce_count_q + CE_CNT_W'(ce_q);
        case (state_q)
            ST_PAUSE: begin
                if (bus.cpu_halt) begin
                    state_d = ST_HALT;
                end else if (run_db) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                    ce_d    = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN holds the divider and issues no partial pulse.
                if (bus.cpu_halt) begin
                    state_d = ST_HALT;
                end else if (!run_db) begin
                    state_d = ST_PAUSE;
                end else if (div_q == term) begin
                    ce_d  = 1'b1;
                    div_d = '0;
                end else if (div_q > term) begin
                    // Rate lowered below the current count: restart silently.
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_STEP: begin
                state_d = ST_PAUSE;
            end
            ST_HALT: begin
                if (!bus.cpu_halt && !run_db) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
    end

    // State, divider, enable and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_PAUSE;
            div_q      <= '0;
            ce_q       <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ce_q       <= ce_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign bus.ce_out    = ce_q;
    assign bus.state_out = state_q;
    assign bus.ce_count  = ce_count_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DEBOUNCE_CYC=4, DIV=8/4/2/1.
// Vector table: each record sets the inputs at a falling edge, waits a
// number of clock cycles, then compares state_out/ce_out/ce_count.
module tb_cpu_clk_ctrl;
    logic clk;
    logic rst;

    cpu_clk_ctrl_if bus ();

    cpu_clk_ctrl #(
        .DEBOUNCE_CYC (4),
        .DIV0         (8),
        .DIV1         (4),
        .DIV2         (2),
        .DIV3         (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_checks;

    typedef struct {
        logic        sw_run;
        logic        btn_step;
        logic [1:0]  freq_sel;
        logic        cpu_halt;
        int          wait_cyc;
        logic [1:0]  exp_state;
        logic        exp_ce;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic sw, input logic btn, input logic [1:0] fs,
                                input logic halt, input int w, input logic [1:0] st,
                                input logic ce, input logic [31:0] cnt);
        vec_t v;
        v.sw_run    = sw;
        v.btn_step  = btn;
        v.freq_sel  = fs;
        v.cpu_halt  = halt;
        v.wait_cyc  = w;
        v.exp_state = st;
        v.exp_ce    = ce;
        v.exp_count = cnt;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [1:0] st,
                                 input logic ce, input logic [31:0] cnt);
        check({tag, " state_out"}, 32'(bus.state_out), 32'(st));
        check({tag, " ce_out"},    32'(bus.ce_out),    32'(ce));
        check({tag, " ce_count"},  bus.ce_count,       cnt);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_pass   = 0;
        n_checks = 0;

        // Step press with 2-cycle bounce, long hold, release.
        vecs.push_back(mk(0, 1, 0, 0,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   6, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 100, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   8, 0, 0, 1));
        // RUN at freq_sel=0: RUN after 7 cycles, pulse every 8.
        vecs.push_back(mk(1, 0, 0, 0,   7, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   7, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,   1, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0,   7, 1, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0,   1, 1, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0,   7, 1, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0,   8, 1, 1, 4));
        vecs.push_back(mk(1, 0, 0, 0,   1, 1, 0, 5));
        // Divider at 6, switch to freq_sel=1: silent wrap, then every 4.
        vecs.push_back(mk(1, 0, 0, 0,   5, 1, 0, 5));
        vecs.push_back(mk(1, 0, 1, 0,   1, 1, 0, 5));
        vecs.push_back(mk(1, 0, 1, 0,   3, 1, 0, 5));
        vecs.push_back(mk(1, 0, 1, 0,   1, 1, 1, 5));
        vecs.push_back(mk(1, 0, 1, 0,   4, 1, 1, 6));
        // freq_sel=3: ce held high.
        vecs.push_back(mk(1, 0, 3, 0,   1, 1, 1, 7));
        vecs.push_back(mk(1, 0, 3, 0,   1, 1, 1, 8));
        vecs.push_back(mk(1, 0, 3, 0,   4, 1, 1, 12));
        // Step edge coincides with cpu_halt: HALT wins, ce stops.
        vecs.push_back(mk(1, 1, 3, 0,   6, 1, 1, 18));
        vecs.push_back(mk(1, 1, 3, 1,   1, 3, 0, 19));
        vecs.push_back(mk(1, 1, 3, 1,   5, 3, 0, 19));
        vecs.push_back(mk(1, 1, 3, 0,   3, 3, 0, 19));
        vecs.push_back(mk(0, 1, 3, 0,   6, 3, 0, 19));
        vecs.push_back(mk(0, 1, 3, 0,   1, 0, 0, 19));

        // Reset state.
        rst          = 1'b0;
        bus.sw_run   = 1'b0;
        bus.btn_step = 1'b0;
        bus.freq_sel = 2'd0;
        bus.cpu_halt = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("in_reset", 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_outputs("idle", 0, 0, 0);
        end

        // Table-driven sequence.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.sw_run   = vecs[i].sw_run;
            bus.btn_step = vecs[i].btn_step;
            bus.freq_sel = vecs[i].freq_sel;
            bus.cpu_halt = vecs[i].cpu_halt;
            repeat (vecs[i].wait_cyc) @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_state,
                          vecs[i].exp_ce, vecs[i].exp_count);
        end

        // Async reset while ce_out is high in RUN.
        bus.btn_step = 1'b0;
        bus.sw_run   = 1'b1;
        bus.freq_sel = 2'd3;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.state_out == 2'd1 && bus.ce_out) seen = 1'b1;
        end
        check("run_ce_reached", 32'(seen), 32'd1);
        #2;
        rst        = 1'b0;
        bus.sw_run = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_outputs("after_reset", 0, 0, 0);

        // Counter wrap on a single step.
        force dut.ce_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ce_count_q;
        check("preload_count", bus.ce_count, 32'hFFFF_FFFF);
        bus.btn_step = 1'b1;
        repeat (7) @(negedge clk);
        check_outputs("wrap_step", 2, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        check_outputs("wrap_done", 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
